// File: rtl/imem_arbiter.sv
// Shares one block-refill memory port between the I-cache (port 0) and the D-cache (port 1).
// IMEM_ARB_RR_EN selects round-robin on contention; otherwise the D-cache wins contention.
module imem_arbiter #(
  parameter int C_BLOCK_SIZE = 2,
  parameter int C_LINE_SIZE  = 32,
  parameter int ADDR_SIZE    = 32,
  localparam int AW = ADDR_SIZE - C_BLOCK_SIZE - 2,
  localparam int BW = (2 ** C_BLOCK_SIZE) * C_LINE_SIZE
) (
  input  logic          a_clk_i,
  input  logic          a_reset_n_i,
  input  logic          p0_read_i,
  input  logic [AW-1:0] p0_addr_i,
  output logic          p0_busywait_o,
  output logic [BW-1:0] p0_read_data_o,
  output logic          p0_read_done_o,
  input  logic          p1_read_i,
  input  logic [AW-1:0] p1_addr_i,
  output logic          p1_busywait_o,
  output logic [BW-1:0] p1_read_data_o,
  output logic          p1_read_done_o,
  output logic          m_read_o,
  output logic [AW-1:0] m_addr_o,
  input  logic          m_busywait_i,
  input  logic [BW-1:0] m_read_data_i,
  input  logic          m_read_done_i
);

  typedef enum logic [1:0] {S_IDLE, S_ISSUE, S_WAIT, S_RESP} state_t;

  state_t state, state_nxt;
  logic   owner;
  logic   any_req;
  logic   grant_sel;
  logic   cap;
  logic   unused_busywait;

  // The memory is sequenced purely by its done pulse; its busy flag carries no extra information.
  assign unused_busywait = m_busywait_i;

  assign any_req = p0_read_i | p1_read_i;
  assign cap     = (state == S_WAIT) & m_read_done_i;

`ifdef IMEM_ARB_RR_EN
  logic last_grant;

  always_comb begin
    grant_sel = p1_read_i;
    if (p0_read_i && p1_read_i) grant_sel = ~last_grant;
  end

  always_ff @(posedge a_clk_i or negedge a_reset_n_i) begin
    if (!a_reset_n_i) begin
      last_grant <= 1'b1;
    end else if (state == S_IDLE && any_req) begin
      last_grant <= grant_sel;
    end
  end
`else
  // Port 1 wins whenever it requests, so it is also the winner under contention.
  always_comb begin
    grant_sel = p1_read_i;
  end
`endif

  always_comb begin
    state_nxt = state;
    case (state)
      S_IDLE:  if (any_req) state_nxt = S_ISSUE;
      S_ISSUE: state_nxt = S_WAIT;
      S_WAIT:  if (m_read_done_i) state_nxt = S_RESP;
      S_RESP:  state_nxt = S_IDLE;
      default: state_nxt = S_IDLE;
    endcase
  end

  always_ff @(posedge a_clk_i or negedge a_reset_n_i) begin
    if (!a_reset_n_i) state <= S_IDLE;
    else              state <= state_nxt;
  end

  always_ff @(posedge a_clk_i or negedge a_reset_n_i) begin
    if (!a_reset_n_i) begin
      owner    <= 1'b0;
      m_read_o <= 1'b0;
      m_addr_o <= '0;
    end else begin
      m_read_o <= (state == S_IDLE) & any_req;
      if (state == S_IDLE && any_req) begin
        owner    <= grant_sel;
        m_addr_o <= grant_sel ? p1_addr_i : p0_addr_i;
      end
    end
  end

  // Data is captured even if the owner has withdrawn; only the done pulse is suppressed.
  always_ff @(posedge a_clk_i or negedge a_reset_n_i) begin
    if (!a_reset_n_i) begin
      p0_read_data_o <= '0;
      p1_read_data_o <= '0;
      p0_read_done_o <= 1'b0;
      p1_read_done_o <= 1'b0;
    end else begin
      p0_read_done_o <= cap & ~owner & p0_read_i;
      p1_read_done_o <= cap &  owner & p1_read_i;
      if (cap && !owner) p0_read_data_o <= m_read_data_i;
      if (cap &&  owner) p1_read_data_o <= m_read_data_i;
    end
  end

  assign p0_busywait_o = p0_read_i & ~((state == S_RESP) & ~owner);
  assign p1_busywait_o = p1_read_i & ~((state == S_RESP) &  owner);

endmodule
